// File: rtl/chameleon_spi_flash_writer.sv
// chameleon_spi_flash_writer: copies a source buffer into SPI NOR flash
// using WREN / optional 4 KiB SE / PP page by page, with RDSR busy polling.
module chameleon_spi_flash_writer #(
   parameter int a_bits     = 14,
   parameter int poll_limit = 2000000,
   parameter int cs_gap     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              erase_en,
   input  logic [23:0]       flash_addr,
   input  logic [a_bits-1:0] start_addr,
   input  logic [15:0]       amount,
   output logic              busy,
   output logic              error,
   output logic              cs_n,
   output logic              spi_req,
   input  logic              spi_ack,
   output logic [7:0]        spi_d,
   input  logic [7:0]        spi_q,
   output logic              req,
   input  logic              ack,
   output logic [a_bits-1:0] a,
   input  logic [7:0]        q
);
   localparam int pw = $clog2(poll_limit + 1);
   localparam int gw = $clog2(cs_gap + 1);

   typedef enum logic [2:0] {IDLE, GAP, SEND, FETCH, XFER, DONE} state_t;
   typedef enum logic [2:0] {C_WREN_E, C_SE, C_POLL_E, C_WREN, C_PP, C_POLL, C_FIN} cmd_t;

   state_t            state, state_nx;
   cmd_t              cmd, cmd_nx, nxt;
   logic [2:0]        idx, idx_nx;
   logic [23:0]       addr, addr_nx;
   logic [15:0]       cnt, cnt_nx;
   logic              erase, erase_nx;
   logic [pw-1:0]     pcnt, pcnt_nx;
   logic [gw-1:0]     gcnt, gcnt_nx;
   logic              cs_n_nx, spi_req_nx, req_nx, error_nx;
   logic [7:0]        spi_d_nx, hdr;
   logic [a_bits-1:0] a_nx;
   logic              data_phase, poll_rd, last;
   logic              unused_q;

   assign unused_q = &{1'b0, spi_q[7:1]};
   assign busy = state != IDLE;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state   <= IDLE;
         cmd     <= C_WREN;
         idx     <= '0;
         addr    <= '0;
         cnt     <= '0;
         erase   <= 1'b0;
         pcnt    <= '0;
         gcnt    <= '0;
         cs_n    <= 1'b1;
         spi_req <= 1'b0;
         spi_d   <= '0;
         req     <= 1'b0;
         a       <= '0;
         error   <= 1'b0;
      end else begin
         state   <= state_nx;
         cmd     <= cmd_nx;
         idx     <= idx_nx;
         addr    <= addr_nx;
         cnt     <= cnt_nx;
         erase   <= erase_nx;
         pcnt    <= pcnt_nx;
         gcnt    <= gcnt_nx;
         cs_n    <= cs_n_nx;
         spi_req <= spi_req_nx;
         spi_d   <= spi_d_nx;
         req     <= req_nx;
         a       <= a_nx;
         error   <= error_nx;
      end

   always_comb begin
      state_nx   = state;
      cmd_nx     = cmd;
      idx_nx     = idx;
      addr_nx    = addr;
      cnt_nx     = cnt;
      erase_nx   = erase;
      pcnt_nx    = pcnt;
      gcnt_nx    = gcnt;
      cs_n_nx    = cs_n;
      spi_req_nx = spi_req;
      spi_d_nx   = spi_d;
      req_nx     = req;
      a_nx       = a;
      error_nx   = error;
      last       = 1'b0;
      data_phase = cmd == C_PP && idx == 3'd4;
      poll_rd    = (cmd == C_POLL || cmd == C_POLL_E) && idx != 3'd0;
      hdr = (cmd == C_WREN_E || cmd == C_WREN) ? 8'h06 :
            (cmd == C_POLL_E || cmd == C_POLL) ? (idx == 3'd0 ? 8'h05 : 8'h00) :
            idx == 3'd0 ? (cmd == C_SE ? 8'h20 : 8'h02) :
            idx == 3'd1 ? addr[23:16] : idx == 3'd2 ? addr[15:8] : addr[7:0];
      // a finished page poll either ends the job or opens the next page
      nxt = cmd == C_WREN_E ? C_SE : cmd == C_SE ? C_POLL_E : cmd == C_POLL_E ? C_WREN :
            cmd == C_WREN ? C_PP : cmd == C_PP ? C_POLL : cnt == 16'd0 ? C_FIN :
            (erase && addr[11:0] == 12'h000) ? C_WREN_E : C_WREN;
      case (state)
         IDLE:
            if (start && amount != 16'd0) begin
               state_nx = GAP;
               gcnt_nx  = '0;
               addr_nx  = flash_addr;
               a_nx     = start_addr;
               cnt_nx   = amount;
               erase_nx = erase_en;
               error_nx = 1'b0;
               cmd_nx   = (erase_en && flash_addr[11:0] == 12'h000) ? C_WREN_E : C_WREN;
            end
         GAP:
            if (gcnt == gw'(cs_gap - 1)) begin
               state_nx = cmd == C_FIN ? DONE : SEND;
               cs_n_nx  = cmd == C_FIN;
               idx_nx   = '0;
               pcnt_nx  = '0;
            end else
               gcnt_nx = gcnt + gw'(1);
         SEND:
            if (spi_ack == spi_req && ack == req) begin
               if (data_phase) begin
                  req_nx   = ~req;
                  state_nx = FETCH;
               end else begin
                  spi_d_nx   = hdr;
                  spi_req_nx = ~spi_req;
                  state_nx   = XFER;
               end
            end
         FETCH:
            if (ack == req && spi_ack == spi_req) begin
               spi_d_nx   = q;
               spi_req_nx = ~spi_req;
               a_nx       = a + a_bits'(1);
               state_nx   = XFER;
            end
         XFER:
            if (spi_ack == spi_req) begin
               state_nx = SEND;
               idx_nx   = (data_phase || poll_rd) ? idx : idx + 3'd1;
               if (data_phase) begin
                  addr_nx = addr + 24'd1;
                  cnt_nx  = cnt - 16'd1;
                  last    = cnt == 16'd1 || addr[7:0] == 8'hff;
               end else if (poll_rd) begin
                  if (!spi_q[0])
                     last = 1'b1;
                  else if (pcnt == pw'(poll_limit - 1)) begin
                     error_nx = 1'b1;
                     cs_n_nx  = 1'b1;
                     state_nx = IDLE;
                  end else
                     pcnt_nx = pcnt + pw'(1);
               end else
                  last = cmd == C_WREN_E || cmd == C_WREN || (cmd == C_SE && idx == 3'd3);
            end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (last) begin
         cs_n_nx  = 1'b1;
         gcnt_nx  = '0;
         state_nx = GAP;
         cmd_nx   = nxt;
      end
   end
endmodule

// File: tb/tb_chameleon_spi_flash_writer.sv
// tb_chameleon_spi_flash_writer: SPI engine / source buffer models, expected
// command-stream model, and per-cycle SPI protocol checks.
module tb_chameleon_spi_flash_writer;
   localparam int ab = 14, pl = 16, cg = 4;

   logic          clk = 0, reset = 1, start = 0, erase_en = 0;
   logic [23:0]   flash_addr = 0;
   logic [ab-1:0] start_addr = 0;
   logic [15:0]   amount = 0;
   logic          busy, error, cs_n, spi_req, req;
   logic [7:0]    spi_d;
   logic [ab-1:0] a;
   logic          spi_ack = 0, ack = 0;
   logic [7:0]    spi_q = 0, q = 0;

   int checks = 0, failures = 0;
   logic [7:0] mem [0:(1<<ab)-1];
   int act[$], exp_q[$];
   int t1_lit[$] = '{6, -1, 2, 0, 0, 'hFE, 'hAA, 'hBB, -1, 5, 0, -1,
                     6, -1, 2, 0, 1, 0, 'hCC, 'hDD, -1, 5, 0, -1};
   int t2_lit[$] = '{6, -1, 'h20, 1, 'h20, 0, -1, 5, 0, -1,
                     6, -1, 2, 1, 'h20, 0, 'h5A, -1, 5, 0, -1};
   int eng_lat = 2, eng_cnt = 0, src_cnt = 0;
   int fr_len = 0, fr_first = 0, busy_left = 0, poll_busy = 0;
   int hi_cnt = 100, falls = 0, falls0 = 0;
   logic [7:0] eng_resp = 0, busy_val = 8'h03, p_d = 0;
   logic [ab-1:0] src_a = 0;
   logic p_req = 0, p_pend = 0, p_cs = 1, stale = 0, found = 0;

   always #5 clk = ~clk;

   chameleon_spi_flash_writer #(.a_bits(ab), .poll_limit(pl), .cs_gap(cg)) dut (
      .clk(clk), .reset(reset), .start(start), .erase_en(erase_en),
      .flash_addr(flash_addr), .start_addr(start_addr), .amount(amount),
      .busy(busy), .error(error), .cs_n(cs_n), .spi_req(spi_req), .spi_ack(spi_ack),
      .spi_d(spi_d), .spi_q(spi_q), .req(req), .ack(ack), .a(a), .q(q));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, expv);
      end
   endtask

   // SPI engine, source buffer and protocol monitor share one negedge loop
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (spi_req != p_req) begin
            check("overlap", p_pend, 0);
            check("cs_lead", p_cs, 0);
         end else if (p_pend && !stale) begin
            check("d_stable", spi_d, p_d);
            check("cs_hold", cs_n, 0);
         end
         if (p_cs && !cs_n) begin
            check("cs_gap", hi_cnt >= cg, 1);
            falls++;
         end
      end
      hi_cnt = cs_n ? hi_cnt + 1 : 0;
      if (!p_cs && cs_n) begin
         act.push_back(-1);
         fr_len = 0;
      end
      if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) begin
            spi_q = eng_resp;
            spi_ack = spi_req;
         end
      end else if (spi_req != spi_ack) begin
         act.push_back(int'(spi_d));
         if (fr_len == 0) begin
            fr_first = int'(spi_d);
            busy_left = poll_busy;
            eng_resp = 8'hFF;
         end else if (fr_first == 5) begin
            eng_resp = busy_left > 0 ? busy_val : 8'h00;
            if (busy_left > 0) busy_left--;
         end else
            eng_resp = 8'hFF;
         fr_len++;
         eng_cnt = eng_lat;
      end
      if (src_cnt > 0) begin
         src_cnt--;
         if (src_cnt == 0) begin
            q = mem[src_a];
            ack = req;
         end
      end else if (req != ack) begin
         src_a = a;
         src_cnt = 2;
      end
      if (reset) stale = 1;
      else if (spi_req == spi_ack) stale = 0;
      p_req = spi_req;
      p_pend = spi_req != spi_ack;
      p_cs = cs_n;
      p_d = spi_d;
   end

   task automatic add_poll(input int reads);
      exp_q.push_back(5);
      repeat (reads) exp_q.push_back(0);
      exp_q.push_back(-1);
   endtask

   task automatic push_addr(input logic [23:0] fa);
      exp_q.push_back(int'(fa[23:16]));
      exp_q.push_back(int'(fa[15:8]));
      exp_q.push_back(int'(fa[7:0]));
   endtask

   task automatic build_exp(input logic [23:0] fa, input logic [ab-1:0] sa, input int n,
                            input logic er, input int reads);
      exp_q.delete();
      while (n > 0) begin
         if (er && fa[11:0] == 12'h000) begin
            exp_q.push_back(6); exp_q.push_back(-1);
            exp_q.push_back('h20); push_addr(fa); exp_q.push_back(-1);
            add_poll(reads);
         end
         exp_q.push_back(6); exp_q.push_back(-1);
         exp_q.push_back(2); push_addr(fa);
         do begin
            exp_q.push_back(int'(mem[sa]));
            sa++; fa++; n--;
         end while (n > 0 && fa[7:0] != 8'h00);
         exp_q.push_back(-1);
         add_poll(reads);
      end
   endtask

   task automatic cmp_stream(input string name, input int e[$]);
      check({name, "_len"}, act.size(), e.size());
      for (int i = 0; i < e.size() && i < act.size(); i++)
         check($sformatf("%s[%0d]", name, i), act[i], e[i]);
   endtask

   task automatic run_job(input logic [23:0] fa, input logic [ab-1:0] sa, input logic [15:0] n,
                          input logic er);
      act.delete();
      flash_addr = fa; start_addr = sa; amount = n; erase_en = er; start = 1;
      @(negedge clk);
      start = 0;
      check("busy_rise", busy, 1);
      check("error_clr", error, 0);
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (busy && t < 20000) begin
         @(negedge clk);
         t++;
      end
      check({name, "_done"}, busy, 0);
   endtask

   initial begin
      for (int i = 0; i < (1 << ab); i++) mem[i] = 8'(i * 37 + 11);
      mem['h100] = 8'hAA; mem['h101] = 8'hBB; mem['h102] = 8'hCC; mem['h103] = 8'hDD;
      mem['h200] = 8'h5A;
      repeat (3) @(negedge clk);
      check("rst_cs_n", cs_n, 1);
      check("rst_busy", busy, 0);
      check("rst_error", error, 0);
      check("rst_spi_req", spi_req, 0);
      check("rst_req", req, 0);
      check("rst_a", a, 0);
      check("rst_spi_d", spi_d, 0);
      reset = 0;
      repeat (2) @(negedge clk);

      // page crossing at 0x0000FF -> 0x000100
      poll_busy = 0;
      build_exp(24'h0000FE, 14'h100, 4, 0, 1);
      run_job(24'h0000FE, 14'h100, 4, 0);
      wait_idle("t1");
      cmp_stream("t1_model", exp_q);
      cmp_stream("t1_lit", t1_lit);
      check("t1_error", error, 0);

      // sector erase before an aligned page
      build_exp(24'h012000, 14'h200, 1, 1, 1);
      run_job(24'h012000, 14'h200, 1, 1);
      wait_idle("t2");
      cmp_stream("t2_model", exp_q);
      cmp_stream("t2_lit", t2_lit);

      // three busy status bytes then ready
      poll_busy = 3; busy_val = 8'h03; falls0 = falls;
      build_exp(24'h000200, 14'h005, 1, 0, 4);
      run_job(24'h000200, 14'h005, 1, 0);
      wait_idle("t3");
      cmp_stream("t3_model", exp_q);
      check("t3_cs_frames", falls - falls0, 3);

      // flash address and source address both wrap, erase on the wrapped page
      poll_busy = 1;
      build_exp(24'hFFFFFF, 14'h3FFF, 2, 1, 2);
      run_job(24'hFFFFFF, 14'h3FFF, 2, 1);
      wait_idle("t7");
      cmp_stream("t7_model", exp_q);

      // status stuck busy -> timeout after poll_limit reads
      poll_busy = 1000; busy_val = 8'h01;
      build_exp(24'h000300, 14'h010, 1, 0, pl);
      run_job(24'h000300, 14'h010, 1, 0);
      wait_idle("t4");
      cmp_stream("t4_model", exp_q);
      check("t4_error", error, 1);
      check("t4_cs_n", cs_n, 1);
      check("t4_busy", busy, 0);
      poll_busy = 0;
      build_exp(24'h000400, 14'h020, 3, 0, 1);
      run_job(24'h000400, 14'h020, 3, 0);
      wait_idle("t4b");
      cmp_stream("t4b_model", exp_q);
      check("t4b_error", error, 0);

      // amount 0 is a no-op
      act.delete(); falls0 = falls;
      amount = 0; flash_addr = 24'h000100; start = 1;
      @(negedge clk);
      start = 0;
      check("t5_busy_zero", busy, 0);
      repeat (20) @(negedge clk);
      check("t5_no_cs", falls - falls0, 0);
      check("t5_no_bytes", act.size(), 0);

      // start while busy is ignored
      build_exp(24'h000500, 14'h030, 3, 0, 1);
      run_job(24'h000500, 14'h030, 3, 0);
      repeat (10) @(negedge clk);
      flash_addr = 24'hABCDEF; start_addr = 14'h1234; amount = 5; erase_en = 1; start = 1;
      @(negedge clk);
      start = 0;
      check("t5_busy_kept", busy, 1);
      wait_idle("t5");
      cmp_stream("t5_model", exp_q);

      // async reset during a PP data byte with a slow engine
      eng_lat = 30;
      run_job(24'h000010, 14'h040, 8, 0);
      found = 0;
      for (int t = 0; t < 5000 && !found; t++) begin
         @(negedge clk);
         found = fr_len >= 5 && fr_first == 2 && spi_req != spi_ack && !spi_req;
      end
      check("t6_reach", found, 1);
      #2 reset = 1;
      #1 check("t6_cs_async", cs_n, 1);
      check("t6_busy", busy, 0);
      @(negedge clk);
      eng_lat = 2;
      reset = 0;
      @(negedge clk);
      build_exp(24'h000600, 14'h050, 2, 0, 1);
      run_job(24'h000600, 14'h050, 2, 0);
      wait_idle("t6");
      cmp_stream("t6_model", exp_q);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
